// File: rtl/marvin_ram_pkg.sv
// Shared types for the marvin RAM utility blocks.
// Holds the ram_copier state encoding so that monitors and other blocks
// can decode the same states.
package marvin_ram_pkg;

   // Copier sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } copier_state_t;

endpackage

// File: rtl/ram_copier_if.sv
// Single-port RAM bus between ram_copier and a RAM with combinational read.
// Ports:
//   ram_ena  - port enable (copier -> RAM)
//   ram_we   - write strobe (copier -> RAM)
//   ram_addr - word address (copier -> RAM)
//   ram_din  - write data (copier -> RAM)
//   ram_dout - read data, combinational on ram_addr (RAM -> copier)
// Modports: master = copier side, slave = RAM side.
interface ram_copier_if #(
   parameter int unsigned DATA_ = 8,
   parameter int unsigned ADDR_ = 8
) ();

   logic             ram_ena;
   logic             ram_we;
   logic [ADDR_-1:0] ram_addr;
   logic [DATA_-1:0] ram_din;
   logic [DATA_-1:0] ram_dout;

   modport master (
      output ram_ena,
      output ram_we,
      output ram_addr,
      output ram_din,
      input  ram_dout
   );

   modport slave (
      input  ram_ena,
      input  ram_we,
      input  ram_addr,
      input  ram_din,
      output ram_dout
   );

endinterface

// File: rtl/ram_copier.sv
// Block copier over a single-port RAM: copies len words from src to dst in
// ascending address order, one read cycle and one write cycle per word.
// Addresses wrap modulo 2**ADDR_; len may be 0 .. 2**ADDR_.
// Optional fill mode (macro RAM_COPIER_FILL_EN): writes a captured pattern to
// len consecutive dst addresses at one word per cycle.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   start         - request pulse, only accepted while idle
//   src, dst, len - transfer description, captured on accept
//   fill, pattern - fill-mode select and data (RAM_COPIER_FILL_EN only)
//   busy          - high in every state except IDLE
//   done          - one-cycle completion pulse
//   ram           - RAM bus (master side), all outputs registered
module ram_copier
   import marvin_ram_pkg::*;
#(
   parameter int unsigned DATA_ = 8,
   parameter int unsigned ADDR_ = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDR_-1:0] src,
   input  logic [ADDR_-1:0] dst,
   input  logic [ADDR_:0]   len,
`ifdef RAM_COPIER_FILL_EN
   input  logic             fill,
   input  logic [DATA_-1:0] pattern,
`endif
   output logic             busy,
   output logic             done,
   ram_copier_if.master     ram
);

   copier_state_t    state;
   logic [ADDR_-1:0] src_q;
   logic [ADDR_-1:0] dst_q;
   logic [ADDR_:0]   cnt_q;

   logic [ADDR_-1:0] src_inc_c;
   logic [ADDR_-1:0] dst_inc_c;
   logic [ADDR_:0]   cnt_dec_c;
   logic             last_c;

`ifdef RAM_COPIER_FILL_EN
   logic             fill_q;
`else
   localparam logic  fill_q = 1'b0;
`endif

   // Address/count updates applied as each word is written
   assign src_inc_c = src_q + ADDR_'(1);
   assign dst_inc_c = dst_q + ADDR_'(1);
   assign cnt_dec_c = cnt_q - (ADDR_+1)'(1);
   assign last_c    = (cnt_q == (ADDR_+1)'(1));

   // Sequencer; RAM outputs are set on entry to the state that uses them.
   // ram.ram_din doubles as the data register holding the word read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         src_q        <= '0;
         dst_q        <= '0;
         cnt_q        <= '0;
         ram.ram_ena  <= 1'b0;
         ram.ram_we   <= 1'b0;
         ram.ram_addr <= '0;
         ram.ram_din  <= '0;
`ifdef RAM_COPIER_FILL_EN
         fill_q       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               ram.ram_ena <= 1'b0;
               ram.ram_we  <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (len == '0) begin
                     // Empty request: report completion without touching RAM
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     src_q <= src;
                     dst_q <= dst;
                     cnt_q <= len;
`ifdef RAM_COPIER_FILL_EN
                     fill_q <= fill;
                     if (fill) begin
                        state        <= ST_WRITE;
                        ram.ram_ena  <= 1'b1;
                        ram.ram_we   <= 1'b1;
                        ram.ram_addr <= dst;
                        ram.ram_din  <= pattern;
                     end else
`endif
                     begin
                        state        <= ST_READ;
                        ram.ram_ena  <= 1'b1;
                        ram.ram_we   <= 1'b0;
                        ram.ram_addr <= src;
                     end
                  end
               end
            end

            ST_READ: begin
               state        <= ST_WRITE;
               ram.ram_we   <= 1'b1;
               ram.ram_addr <= dst_q;
               ram.ram_din  <= ram.ram_dout;
            end

            ST_WRITE: begin
               src_q <= src_inc_c;
               dst_q <= dst_inc_c;
               cnt_q <= cnt_dec_c;
               if (last_c) begin
                  state       <= ST_DONE;
                  done        <= 1'b1;
                  ram.ram_ena <= 1'b0;
                  ram.ram_we  <= 1'b0;
               end else if (fill_q) begin
                  // Fill streams writes back to back; pattern stays in ram_din
                  state        <= ST_WRITE;
                  ram.ram_addr <= dst_inc_c;
               end else begin
                  state        <= ST_READ;
                  ram.ram_we   <= 1'b0;
                  ram.ram_addr <= src_inc_c;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_copier.sv
// Self-checking bench for ram_copier: behavioural RAM, array-based reference
// copy/fill model, directed corner cases plus randomized transfers.
// Fill-mode checks are compiled when RAM_COPIER_FILL_EN is defined.
module tb_ram_copier;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [ADDR_W:0]   len;
`ifdef RAM_COPIER_FILL_EN
   logic              fill;
   logic [DATA_W-1:0] pattern;
`endif
   logic              busy;
   logic              done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DATA_W-1:0] mem      [DEPTH];
   logic [DATA_W-1:0] init_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem  [DEPTH];
   logic              load;
   logic [ADDR_W-1:0] rd_log [$];

   ram_copier_if #(.DATA_(DATA_W), .ADDR_(ADDR_W)) ram ();

   ram_copier #(.DATA_(DATA_W), .ADDR_(ADDR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .src     (src),
      .dst     (dst),
      .len     (len),
`ifdef RAM_COPIER_FILL_EN
      .fill    (fill),
      .pattern (pattern),
`endif
      .busy    (busy),
      .done    (done),
      .ram     (ram)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, synchronous write, bulk preload
   assign ram.ram_dout = mem[ram.ram_addr];

   always @(posedge clk) begin
      if (load)
         mem <= init_mem;
      else if (ram.ram_ena && ram.ram_we)
         mem[ram.ram_addr] <= ram.ram_din;
   end

   // Trace of read addresses presented to the RAM
   always @(posedge clk) begin
      if (ram.ram_ena && !ram.ram_we)
         rd_log.push_back(ram.ram_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rand_init();
      for (int i = 0; i < int'(DEPTH); i++)
         init_mem[i] = DATA_W'($urandom);
   endtask

   task automatic load_mem();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      ref_mem = init_mem;
   endtask

   task automatic check_mem(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < int'(DEPTH); i++)
         if (mem[i] !== ref_mem[i]) nbad++;
      check({tag, ".mem"}, 32'(nbad), 32'd0);
   endtask

   // Runs one transfer and checks timing, RAM activity, read order and contents
   task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                           input bit f, input logic [7:0] p, input bit poke, input string tag);
      logic [7:0] exp_rd [$];
      logic [7:0] a;
      logic [7:0] b;
      int busy_n, done_n, done_at, ena_n, we_n, we_run, we_best, rd_base, nbad, k;
      int exp_busy, exp_ena;
      bit fin;

      // Reference: ascending word-by-word copy, or fill with the pattern
      for (int i = 0; i < int'(l); i++) begin
         a = s + 8'(i);
         b = d + 8'(i);
         if (f) begin
            ref_mem[b] = p;
         end else begin
            exp_rd.push_back(a);
            ref_mem[b] = ref_mem[a];
         end
      end
      if (l == 0) begin
         exp_busy = 1;
         exp_ena  = 0;
      end else if (f) begin
         exp_busy = int'(l) + 1;
         exp_ena  = int'(l);
      end else begin
         exp_busy = 2 * int'(l) + 1;
         exp_ena  = 2 * int'(l);
      end

      busy_n = 0; done_n = 0; done_at = 0; ena_n = 0; we_n = 0; we_run = 0; we_best = 0;
      fin = 1'b0;

      @(negedge clk);
      rd_base = rd_log.size();
      start = 1'b1;
      src   = s;
      dst   = d;
      len   = l;
`ifdef RAM_COPIER_FILL_EN
      fill    = f;
      pattern = p;
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
      src   = 8'($urandom);
      dst   = 8'($urandom);
      len   = 9'($urandom_range(0, 300));

      for (k = 1; k <= 1100 && !fin; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_at = k;
         end
         if (ram.ram_ena) ena_n++;
         if (ram.ram_ena && ram.ram_we) begin
            we_n++;
            we_run++;
            if (we_run > we_best) we_best = we_run;
         end else begin
            we_run = 0;
         end
         if (!busy) fin = 1'b1;
         // Request while busy must be dropped
         if (poke && k == 3) begin
            start = 1'b1;
            src   = 8'($urandom);
            dst   = 8'($urandom);
            len   = 9'($urandom_range(1, 20));
         end
         if (poke && k == 4) start = 1'b0;
      end

      check({tag, ".finished"}, 32'(fin), 32'd1);
      check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
      check({tag, ".done_cycle"}, 32'(done_at), 32'(exp_busy));
      check({tag, ".ena_cycles"}, 32'(ena_n), 32'(exp_ena));
      check({tag, ".we_cycles"}, 32'(we_n), 32'(l));
      if (f)
         check({tag, ".we_consecutive"}, 32'(we_best), 32'(l));
      check({tag, ".reads"}, 32'(rd_log.size() - rd_base), 32'(exp_rd.size()));
      nbad = 0;
      for (int i = 0; i < exp_rd.size(); i++)
         if (rd_base + i >= rd_log.size() || rd_log[rd_base + i] !== exp_rd[i]) nbad++;
      check({tag, ".read_order"}, 32'(nbad), 32'd0);
      check_mem(tag);
   endtask

   // Reset during the second write of a 4-word copy
   task automatic reset_abort();
      int done_n;
      logic [7:0] s;
      logic [7:0] d;
      done_n = 0;
      s = 8'h40;
      d = 8'h90;
      rand_init();
      load_mem();
      @(negedge clk);
      start = 1'b1;
      src   = s;
      dst   = d;
      len   = 9'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         if (done) done_n++;
         @(posedge clk);
         #1;
      end
      check("abort.in_write2_we", 32'(ram.ram_we), 32'd1);
      check("abort.in_write2_addr", 32'(ram.ram_addr), 32'(d + 8'd1));
      #2;
      rst = 1'b1;
      #1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.ena", 32'(ram.ram_ena), 32'd0);
      check("abort.addr", 32'(ram.ram_addr), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) done_n++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) done_n++;
      end
      check("abort.done_pulses", 32'(done_n), 32'd0);
      check("abort.busy_after", 32'(busy), 32'd0);
      ref_mem[d] = ref_mem[s];
      check_mem("abort");
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      src   = '0;
      dst   = '0;
      len   = '0;
      load  = 1'b0;
`ifdef RAM_COPIER_FILL_EN
      fill    = 1'b0;
      pattern = '0;
`endif
      #12;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.ena", 32'(ram.ram_ena), 32'd0);
      check("reset.we", 32'(ram.ram_we), 32'd0);
      check("reset.addr", 32'(ram.ram_addr), 32'd0);
      check("reset.din", 32'(ram.ram_din), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Four-word directed copy
      rand_init();
      init_mem[8'h10] = 8'hA1;
      init_mem[8'h11] = 8'hB2;
      init_mem[8'h12] = 8'hC3;
      init_mem[8'h13] = 8'hD4;
      load_mem();
      run_xfer(8'h10, 8'h80, 9'd4, 1'b0, 8'h00, 1'b0, "copy4");
      check("copy4.word0", 32'(mem[8'h80]), 32'h0A1);
      check("copy4.word3", 32'(mem[8'h83]), 32'h0D4);

      // Zero-length request
      run_xfer(8'h33, 8'h44, 9'd0, 1'b0, 8'h00, 1'b0, "len0");

      // Source wraps past the top of memory
      rand_init();
      load_mem();
      run_xfer(8'hFE, 8'h01, 9'd3, 1'b0, 8'h00, 1'b0, "wrap");

      // start pulsed while busy
      run_xfer(8'h20, 8'hA0, 9'd6, 1'b0, 8'h00, 1'b1, "ignore_start");

      reset_abort();

      // Randomized copies
      for (int t = 0; t < 6; t++) begin
         rand_init();
         load_mem();
         run_xfer(8'($urandom), 8'($urandom), 9'($urandom_range(0, 24)), 1'b0, 8'h00,
                  1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
      end

      // Whole-memory copy
      rand_init();
      load_mem();
      run_xfer(8'($urandom), 8'($urandom), 9'd256, 1'b0, 8'h00, 1'b0, "full");

`ifdef RAM_COPIER_FILL_EN
      rand_init();
      load_mem();
      run_xfer(8'h00, 8'h20, 9'd8, 1'b1, 8'h5A, 1'b0, "fill8");
      check("fill8.word7", 32'(mem[8'h27]), 32'h05A);
      run_xfer(8'h00, 8'($urandom), 9'($urandom_range(1, 40)), 1'b1, 8'($urandom), 1'b1, "fill_rand");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
